multi_tone_osc: RTL
===================

// Module: multi_tone_osc
// PURPOSE
//   Parametrised N-channel square-wave tone generator; successor to fixed three-tone oscillator.
//   Per-channel period and enable are programmed at run time over a one-cycle write port.
//   Period changes apply glitch-free at the next half-period boundary.
//   Sits between the control/register logic and audio output pins or a downstream mixer.
// PARAMETERS
//   NCH    3   number of tone channels (1..16)
//   WIDTH  32  period counter/register width in bits
//   AW     derived localparam = max(1,$clog2(NCH)); channel address width
// PORTS
//   CLK        in   1      system clock, all logic on rising edge
//   RST_N      in   1      asynchronous active-low reset
//   wr_en      in   1      period write strobe, single cycle
//   wr_addr    in   AW     channel index for write
//   wr_data    in   WIDTH  new half-period in CLK cycles
//   chan_en    in   NCH    per-channel run enable (level)
//   tone_out   out  NCH    square-wave outputs
//   sync_out   out  NCH    one-cycle pulse on each rising edge of tone_out[i]
//   upd_pend   out  NCH    1 while a written period waits for its boundary
//   mix_out    out  $clog2(NCH+1)  only with TONE_MIX_EN (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, RST_N=0): active period, pending period, counter = 0; tone_out, sync_out,
//     upd_pend = 0; mix_out = 0. Deassertion takes effect on next CLK edge.
//   Channel i "running" when chan_en[i]=1 and active period P != 0; else "idle".
//   Running: counter counts 0..P-1; at count P-1 (boundary) tone_out toggles, counter -> 0.
//     Output period = 2*P cycles, 50% duty. P=1 toggles every cycle.
//   First toggle after entering running: tone_out goes 0->1 exactly P cycles after the
//     cycle in which running first holds (counter starts at 0).
//   Idle: counter held 0, tone_out forced 0 on next edge (registered), sync_out 0.
//   sync_out[i] = 1 for the single cycle in which registered tone_out[i] is 1 and was 0.
//   Write (wr_en=1, wr_addr=i < NCH): wr_data -> pending[i], upd_pend[i] <= 1.
//     wr_addr >= NCH: write ignored, no state change.
//   Pending load: at channel's boundary, active <= pending, upd_pend <= 0; counter restarts
//     at 0 with new P. If channel idle, pending loads on next edge (upd_pend high 1 cycle).
//   Write in same cycle as boundary on same channel: wr_data loaded directly into active,
//     upd_pend stays/becomes 0 (the bypass wins over older pending value).
//   Repeated writes before boundary: last write wins.
//   Writing P=0 to running channel: applied at boundary; channel then idle, tone_out -> 0.
//   chan_en deassert mid-period: counter and tone_out cleared next edge; pending preserved
//     and loaded immediately (idle rule). Re-enable restarts phase from 0, output low.
//   Channels independent; no cross-channel phase alignment. Counter never exceeds P-1
//     (compare uses >= P-1 so a lower P via bypass cannot overrun).
// CONFIGURATION
//   TONE_MIX_EN defined: mix_out port present; registered count of tone_out bits high,
//     updated each cycle, 1-cycle latency after tone_out; reset 0.
//   TONE_MIX_EN undefined: mix_out port and adder tree absent; all else identical.
// STRUCTURE
//   Package osc_pkg: default NCH/WIDTH constants, localparam function for AW,
//     typedef for period word (logic [WIDTH-1:0] via parameterised usage).
//   Sub-module tone_chan (one per channel, generate loop): counter, active/pending
//     registers, upd_pend flag, tone/sync flops. Top: address decode, optional mix adder.
// TESTING
//   T1 reset: hold RST_N=0 mid-toggle -> all outputs 0 immediately; release -> stay 0 until enabled.
//   T2 basic: write ch0 P=4, chan_en=001 -> tone_out[0] rises at cycle 4, period 8, sync pulses every 8.
//   T3 glitch-free: ch1 running P=10, write P=3 at count 5 -> upd_pend[1]=1 until count 9, then
//      next half-period is 3 cycles; no half-period shorter than 10 before that.
//   T4 bypass: write ch2 exactly at its boundary cycle -> new P used for next half, upd_pend[2] stays 0.
//   T5 bounds: P=1 -> toggles every cycle; P=0 -> tone 0; wr_addr=NCH -> no channel changes.
//   T6 TONE_MIX_EN build: all 3 channels P=1 in phase -> mix_out alternates 3/0 one cycle delayed.

Source files
------------

// File: rtl/multi_tone_osc_pkg.sv
// multi_tone_osc_pkg: shared defaults and the channel-address width helper for the tone oscillator
package multi_tone_osc_pkg;
  localparam int DEF_NCH = 3;
  localparam int DEF_WIDTH = 32;
  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_tone_osc_tone_chan.sv
// multi_tone_osc_tone_chan: one square-wave channel with a boundary-synchronised period update
//   clk, rst_n : clock and asynchronous active-low reset
//   wr         : this channel is the target of the write strobe
//   wr_data    : new half-period in clk cycles
//   en         : run enable (level)
//   tone       : square-wave output, 2*P cycle period
//   sync       : one-cycle pulse in the cycle tone first reads 1
//   upd_pend   : a written period is waiting for its boundary
module multi_tone_osc_tone_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             en,
  output logic             tone,
  output logic             sync,
  output logic             upd_pend
);
  typedef logic [WIDTH-1:0] period_t;
  period_t active, pending, cnt;
  period_t active_d, pending_d, cnt_d;
  logic run, bnd, bypass, load, tone_d, upd_d;
  // The >= compare keeps the counter bounded even if active shrinks under it.
  // An idle channel takes its pending period on the next edge, except when a
  // fresh write arrives in the same cycle: that write becomes the new pending.
  always_comb begin
    run = en && (active != '0);
    bnd = run && (cnt >= active - period_t'(1));
    bypass = bnd && wr;
    load = upd_pend && !wr && (bnd || !run);
    cnt_d = (run && !bnd) ? cnt + period_t'(1) : '0;
    tone_d = run ? (tone ^ bnd) : 1'b0;
    active_d = bypass ? wr_data : load ? pending : active;
    pending_d = (wr && !bypass) ? wr_data : pending;
    upd_d = (bypass || load) ? 1'b0 : wr ? 1'b1 : upd_pend;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
      pending <= '0;
      cnt <= '0;
      tone <= 1'b0;
      sync <= 1'b0;
      upd_pend <= 1'b0;
    end else begin
      active <= active_d;
      pending <= pending_d;
      cnt <= cnt_d;
      tone <= tone_d;
      sync <= tone_d & ~tone;
      upd_pend <= upd_d;
    end
  end
endmodule

// File: rtl/multi_tone_osc.sv
// multi_tone_osc: N-channel square-wave tone generator with run-time programmable half-periods
//   clk, rst_n : clock and asynchronous active-low reset
//   wr_en      : single-cycle period write strobe
//   wr_addr    : channel index; indices >= NCH are ignored
//   wr_data    : new half-period in clk cycles (0 parks the channel)
//   chan_en    : per-channel run enable
//   tone_out   : square-wave outputs
//   sync_out   : one-cycle pulse on each rising edge of tone_out
//   upd_pend   : per-channel pending-period flag
//   mix_out    : registered count of tone_out bits high (only when TONE_MIX_EN is defined)
module multi_tone_osc
  import multi_tone_osc_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int WIDTH = DEF_WIDTH,
  localparam int AW = aw_of(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NCH-1:0]   chan_en,
  output logic [NCH-1:0]   tone_out,
  output logic [NCH-1:0]   sync_out,
  output logic [NCH-1:0]   upd_pend
`ifdef TONE_MIX_EN
  ,
  output logic [$clog2(NCH+1)-1:0] mix_out
`endif
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    multi_tone_osc_tone_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr_en && (wr_addr == AW'(i))),
      .wr_data  (wr_data),
      .en       (chan_en[i]),
      .tone     (tone_out[i]),
      .sync     (sync_out[i]),
      .upd_pend (upd_pend[i])
    );
  end
`ifdef TONE_MIX_EN
  localparam int MW = $clog2(NCH + 1);
  logic [MW-1:0] ones;
  always_comb begin
    ones = '0;
    for (int k = 0; k < NCH; k++) ones = ones + MW'(tone_out[k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mix_out <= '0;
    else mix_out <= ones;
  end
`endif
endmodule
